// File: rtl/exu_pkg.sv
// Shared definitions for the EXU: data width, opcode map, FSM states and
// decode helpers used by both the ALU and the control/register-file top.
package exu_pkg;

   localparam int DATA_W   = 8;
   localparam int NUM_REGS = 4;
   localparam int OP_W     = 4;

   localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
   localparam logic [OP_W-1:0] OP_LDI  = 4'd1;
   localparam logic [OP_W-1:0] OP_MOV  = 4'd2;
   localparam logic [OP_W-1:0] OP_ADD  = 4'd3;
   localparam logic [OP_W-1:0] OP_ADC  = 4'd4;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd5;
   localparam logic [OP_W-1:0] OP_AND  = 4'd6;
   localparam logic [OP_W-1:0] OP_OR   = 4'd7;
   localparam logic [OP_W-1:0] OP_XOR  = 4'd8;
   localparam logic [OP_W-1:0] OP_INC  = 4'd9;
   localparam logic [OP_W-1:0] OP_DEC  = 4'd10;
   localparam logic [OP_W-1:0] OP_SHL  = 4'd11;
   localparam logic [OP_W-1:0] OP_SHR  = 4'd12;
   localparam logic [OP_W-1:0] OP_JMPS = 4'd13;
   localparam logic [OP_W-1:0] OP_JMP  = 4'd14;
   localparam logic [OP_W-1:0] OP_EOP  = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXEC   = 2'd1,
      ST_DONE   = 2'd2,
      ST_SETTLE = 2'd3
   } state_t;

   // Jump opcodes are resolved by the fetch unit; here they behave as NOP.
   function automatic logic writes_rd(input logic [OP_W-1:0] op);
      return (op >= OP_LDI) && (op <= OP_SHR);
   endfunction

   function automatic logic sets_flags(input logic [OP_W-1:0] op);
      return (op >= OP_ADD) && (op <= OP_SHR);
   endfunction

endpackage

// File: rtl/exu_alu.sv
// Combinational 8-bit ALU: result plus carry/borrow and zero flags.
module exu_alu
   import exu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cf_in,
   input  logic [OP_W-1:0]   opcode,
   output logic [DATA_W-1:0] result,
   output logic              cf_out,
   output logic              zf_out
);

   localparam logic [DATA_W:0] ONE_W = {{DATA_W{1'b0}}, 1'b1};

   // Ninth bit carries the carry-out on add and the borrow on subtract.
   logic [DATA_W:0] wide;

   always_comb begin
      result = a;
      cf_out = cf_in;
      wide   = '0;
      case (opcode)
         OP_LDI, OP_MOV: result = b;
         OP_ADD: begin
            wide   = {1'b0, a} + {1'b0, b};
            result = wide[DATA_W-1:0];
            cf_out = wide[DATA_W];
         end
         OP_ADC: begin
            wide   = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cf_in};
            result = wide[DATA_W-1:0];
            cf_out = wide[DATA_W];
         end
         OP_SUB: begin
            wide   = {1'b0, a} - {1'b0, b};
            result = wide[DATA_W-1:0];
            cf_out = wide[DATA_W];
         end
         OP_AND: begin
            result = a & b;
            cf_out = 1'b0;
         end
         OP_OR: begin
            result = a | b;
            cf_out = 1'b0;
         end
         OP_XOR: begin
            result = a ^ b;
            cf_out = 1'b0;
         end
         OP_INC: begin
            wide   = {1'b0, a} + ONE_W;
            result = wide[DATA_W-1:0];
            cf_out = wide[DATA_W];
         end
         OP_DEC: begin
            wide   = {1'b0, a} - ONE_W;
            result = wide[DATA_W-1:0];
            cf_out = wide[DATA_W];
         end
         OP_SHL: begin
            result = {a[DATA_W-2:0], 1'b0};
            cf_out = a[DATA_W-1];
         end
         OP_SHR: begin
            result = {1'b0, a[DATA_W-1:1]};
            cf_out = a[0];
         end
         default: begin
            result = a;
            cf_out = cf_in;
         end
      endcase
   end

   assign zf_out = (result == '0);

endmodule

// File: rtl/exu.sv
// Execution unit: four-state handshake FSM, 4x8 register file and flags,
// with arithmetic delegated to exu_alu.
module exu
   import exu_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              instr_valid_i,
   input  logic [15:0]       instr_i,
   output logic              instr_done_o,
   output logic              cf_o,
   output logic              zf_o,
   output logic              busy_o,
   input  logic [1:0]        dbg_sel_i,
   output logic [DATA_W-1:0] dbg_data_o
);

   state_t            state_reg, state_next;
   logic [15:0]       instr_reg;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              cf_reg, zf_reg;

   logic [OP_W-1:0]   opcode;
   logic [1:0]        rd, rs;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] alu_b, alu_result;
   logic              alu_cf, alu_zf;
   logic              write_en, flag_en;

   assign opcode = instr_reg[15:12];
   assign rd     = instr_reg[11:10];
   assign rs     = instr_reg[9:8];
   assign imm    = instr_reg[7:0];

   // LDI routes the immediate through the ALU's b operand.
   assign alu_b = (opcode == OP_LDI) ? imm : regs[rs];

   exu_alu u_alu (
      .a      (regs[rd]),
      .b      (alu_b),
      .cf_in  (cf_reg),
      .opcode (opcode),
      .result (alu_result),
      .cf_out (alu_cf),
      .zf_out (alu_zf)
   );

   assign write_en = (state_reg == ST_EXEC) && writes_rd(opcode);
   assign flag_en  = (state_reg == ST_EXEC) && sets_flags(opcode);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (instr_valid_i) state_next = ST_EXEC;
         ST_EXEC:   state_next = ST_DONE;
         ST_DONE:   state_next = ST_SETTLE;
         ST_SETTLE: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         instr_reg <= '0;
         cf_reg    <= 1'b0;
         zf_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_IDLE && instr_valid_i) instr_reg <= instr_i;
         if (flag_en) begin
            cf_reg <= alu_cf;
            zf_reg <= alu_zf;
         end
      end
   end

   // Both operands were read from regs before this edge, so rd==rs is safe.
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regfile
         always_ff @(posedge clock) begin
            if (!reset_n) regs[gi] <= '0;
            else if (write_en && (rd == gi[1:0])) regs[gi] <= alu_result;
         end
      end
   endgenerate

   assign instr_done_o = (state_reg == ST_DONE);
   assign busy_o       = (state_reg != ST_IDLE);
   assign cf_o         = cf_reg;
   assign zf_o         = zf_reg;
   assign dbg_data_o   = regs[dbg_sel_i];

endmodule

// File: tb/tb_exu.sv
// Randomized self-checking bench for exu against an integer reference model.
`timescale 1ns/100ps
module tb_exu;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        instr_valid_i;
   logic [15:0] instr_i;
   logic        instr_done_o, cf_o, zf_o, busy_o;
   logic [1:0]  dbg_sel_i;
   logic [7:0]  dbg_data_o;

   int errors = 0;
   int checks = 0;

   int m_r [4];
   int m_cf, m_zf;

   exu dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .instr_valid_i(instr_valid_i),
      .instr_i      (instr_i),
      .instr_done_o (instr_done_o),
      .cf_o         (cf_o),
      .zf_o         (zf_o),
      .busy_o       (busy_o),
      .dbg_sel_i    (dbg_sel_i),
      .dbg_data_o   (dbg_data_o)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int imm);
      logic [15:0] w;
      w = {op[3:0], rd[1:0], rs[1:0], imm[7:0]};
      return w;
   endfunction

   // Reference: applies one instruction to the model using plain integer arithmetic.
   task automatic model_exec(input logic [15:0] w);
      int op, rd, rs, imm, a, b, s, res;
      bit flags;
      op  = int'(w[15:12]);
      rd  = int'(w[11:10]);
      rs  = int'(w[9:8]);
      imm = int'(w[7:0]);
      a   = m_r[rd];
      b   = m_r[rs];
      res = a;
      flags = 1'b1;
      case (op)
         1:  begin res = imm; flags = 1'b0; end
         2:  begin res = b;   flags = 1'b0; end
         3:  begin s = a + b;        res = s % 256; m_cf = (s > 255); end
         4:  begin s = a + b + m_cf; res = s % 256; m_cf = (s > 255); end
         5:  begin m_cf = (a < b); res = (a - b + 256) % 256; end
         6:  begin res = a & b; m_cf = 0; end
         7:  begin res = a | b; m_cf = 0; end
         8:  begin res = a ^ b; m_cf = 0; end
         9:  begin res = (a + 1) % 256; m_cf = (a == 255); end
         10: begin res = (a + 255) % 256; m_cf = (a == 0); end
         11: begin res = (a * 2) % 256; m_cf = (a >= 128); end
         12: begin res = a / 2; m_cf = a % 2; end
         default: flags = 1'b0;
      endcase
      if (op >= 1 && op <= 12) m_r[rd] = res;
      if (flags) m_zf = (res == 0);
   endtask

   task automatic compare_state(input string tag);
      for (int i = 0; i < 4; i++) begin
         dbg_sel_i = i[1:0];
         #0.5;
         check($sformatf("%s_R%0d", tag, i), int'(dbg_data_o), m_r[i]);
      end
      check({tag, "_cf"}, int'(cf_o), m_cf);
      check({tag, "_zf"}, int'(zf_o), m_zf);
   endtask

   task automatic expect_reg(input int idx, input int val);
      dbg_sel_i = idx[1:0];
      #0.5;
      check($sformatf("spec_R%0d", idx), int'(dbg_data_o), val);
   endtask

   // Issues one instruction from IDLE with valid held through SETTLE and one
   // more edge, so a second accept of the same word would show up as busy.
   task automatic run_instr(input logic [15:0] w);
      instr_i = w;
      instr_valid_i = 1'b1;
      @(posedge clock); #1;
      check("exec_busy", int'(busy_o), 1);
      check("exec_done", int'(instr_done_o), 0);
      @(posedge clock); #1;
      check("done_pulse", int'(instr_done_o), 1);
      @(posedge clock); #1;
      check("settle_done", int'(instr_done_o), 0);
      check("settle_busy", int'(busy_o), 1);
      @(posedge clock); #1;
      check("idle_busy", int'(busy_o), 0);
      instr_valid_i = 1'b0;
      model_exec(w);
      $display("instr 0x%04h op=%0d rd=%0d rs=%0d imm=0x%02h cf=%0d zf=%0d",
               w, w[15:12], w[11:10], w[9:8], w[7:0], cf_o, zf_o);
      compare_state("st");
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_cf = 0;
      m_zf = 0;
   endtask

   initial begin
      reset_n = 1'b0;
      instr_valid_i = 1'b0;
      instr_i = '0;
      dbg_sel_i = '0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", int'(busy_o), 0);
      check("rst_done", int'(instr_done_o), 0);
      compare_state("rst");

      // Accept in the very first cycle after release.
      reset_n = 1'b1;
      run_instr(enc(1, 0, 0, 8'h05));
      expect_reg(0, 8'h05);
      check("spec_ldi_cf", int'(cf_o), 0);

      run_instr(enc(1, 1, 0, 8'hF0));
      run_instr(enc(1, 2, 0, 8'h20));
      run_instr(enc(3, 1, 2, 0));
      expect_reg(1, 8'h10);
      check("spec_add_cf", int'(cf_o), 1);
      check("spec_add_zf", int'(zf_o), 0);
      run_instr(enc(4, 2, 2, 0));
      expect_reg(2, 8'h41);
      check("spec_adc_cf", int'(cf_o), 0);

      run_instr(enc(1, 3, 0, 8'h00));
      run_instr(enc(10, 3, 0, 0));
      expect_reg(3, 8'hFF);
      check("spec_dec_cf", int'(cf_o), 1);
      run_instr(enc(9, 3, 0, 0));
      expect_reg(3, 8'h00);
      check("spec_inc_cf", int'(cf_o), 1);
      check("spec_inc_zf", int'(zf_o), 1);

      run_instr(enc(1, 0, 0, 8'h81));
      run_instr(enc(12, 0, 0, 0));
      expect_reg(0, 8'h40);
      check("spec_shr_cf", int'(cf_o), 1);
      run_instr(enc(11, 0, 0, 0));
      expect_reg(0, 8'h80);
      check("spec_shl_cf", int'(cf_o), 0);
      run_instr(enc(8, 0, 0, 0));
      expect_reg(0, 8'h00);
      check("spec_xor_zf", int'(zf_o), 1);
      check("spec_xor_cf", int'(cf_o), 0);

      run_instr(enc(14, 1, 2, 8'hAA));
      run_instr(enc(15, 3, 1, 8'h55));
      run_instr(enc(13, 2, 3, 8'h11));

      // Reset while LDI R2,0x7F sits in EXEC: no write-back, no done pulse.
      instr_i = enc(1, 2, 0, 8'h7F);
      instr_valid_i = 1'b1;
      @(posedge clock); #1;
      check("pre_rst_busy", int'(busy_o), 1);
      reset_n = 1'b0;
      instr_valid_i = 1'b0;
      @(posedge clock); #1;
      check("mid_rst_done", int'(instr_done_o), 0);
      check("mid_rst_busy", int'(busy_o), 0);
      model_reset();
      expect_reg(2, 8'h00);
      compare_state("mid_rst");
      reset_n = 1'b1;

      for (int n = 0; n < 200; n++) begin
         logic [15:0] w;
         w = 16'($urandom);
         // Bias toward loads early so the register file holds varied data.
         if (n < 8) w[15:12] = 4'd1;
         if ($urandom_range(0, 3) == 0) begin
            instr_i = 16'($urandom);
            repeat ($urandom_range(1, 3)) @(posedge clock);
            #1;
            check("idle_hold", int'(busy_o), 0);
         end
         run_instr(w);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
